// File: rtl/atm_pkg.sv
// Shared ATM definitions: opcodes, FSM encoding, flag bundle and account-table reset image.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package atm_pkg;

  localparam int NUM_ACCTS = 4;
  localparam int IDX_W     = 2;

  typedef logic [16:0]      acct_t;
  typedef logic [16:0]      pin_t;
  typedef logic [14:0]      amount_t;
  typedef logic [IDX_W-1:0] idx_t;

  localparam logic [2:0] OP_BALANCE    = 3'b001;
  localparam logic [2:0] OP_WITHDRAW   = 3'b010;
  localparam logic [2:0] OP_DEPOSIT    = 3'b011;
  localparam logic [2:0] OP_TRANSFER   = 3'b100;
  localparam logic [2:0] OP_CHANGE_PIN = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AUTH,
    ST_MENU,
    ST_EXEC,
    ST_DONE,
    ST_ANOTHER
  } state_t;

  // One bit per status output; at most one is set in any cycle.
  typedef struct packed {
    logic transfer;
    logic finished;
    logic balance;
    logic deposit;
    logic withdraw;
    logic pin;
    logic receipt;
  } flags_t;

  // Account numbers are fixed; only PINs and balances are writable.
  function automatic acct_t init_account(input idx_t idx);
    case (idx)
      2'd0:    return 17'h0C5AA;
      2'd1:    return 17'h0705C;
      2'd2:    return 17'h004D2;
      default: return 17'h09ABC;
    endcase
  endfunction

  function automatic pin_t init_pin(input idx_t idx);
    case (idx)
      2'd0:    return 17'h01F5E;
      2'd1:    return 17'h00F0F;
      2'd2:    return 17'h02468;
      default: return 17'h01357;
    endcase
  endfunction

  function automatic amount_t init_balance(input idx_t idx);
    case (idx)
      2'd0:    return 15'h0500;
      2'd1:    return 15'h0200;
      2'd2:    return 15'h0100;
      default: return 15'h7F00;
    endcase
  endfunction

  function automatic logic opcode_valid(input logic [2:0] op);
    return (op == OP_BALANCE) || (op == OP_WITHDRAW) || (op == OP_DEPOSIT) ||
           (op == OP_TRANSFER) || (op == OP_CHANGE_PIN);
  endfunction

endpackage

// File: rtl/atm_banking_system_if.sv
// Customer-facing ATM signal bundle: session controls, operands and status flags.
// Latency: n/a (wiring only).
// Backpressure: none; the controller samples inputs every clock.
interface atm_banking_system_if;
  logic        Card_in;
  logic        Timer;
  logic        money_counting;
  logic        another_transaction_bit;
  logic [2:0]  opcode;
  logic [16:0] password;
  logic [16:0] new_pin;
  logic        take_receipt;
  logic [16:0] ur_account;
  logic [16:0] Pers_Account_No;
  logic [14:0] withdraw_amount;
  logic [14:0] Transfer_Amount;
  logic [14:0] deposit_amount;

  logic Transfer_Successfully;
  logic ATM_Usage_Finished;
  logic Balance_Shown;
  logic Deposited_Successfully;
  logic Withdrew_Successfully;
  logic Pin_Changed_Successfully;
  logic Receipt_Printed;

  modport master (
    output Card_in, Timer, money_counting, another_transaction_bit, opcode,
           password, new_pin, take_receipt, ur_account, Pers_Account_No,
           withdraw_amount, Transfer_Amount, deposit_amount,
    input  Transfer_Successfully, ATM_Usage_Finished, Balance_Shown,
           Deposited_Successfully, Withdrew_Successfully, Pin_Changed_Successfully,
           Receipt_Printed
  );

  modport slave (
    input  Card_in, Timer, money_counting, another_transaction_bit, opcode,
           password, new_pin, take_receipt, ur_account, Pers_Account_No,
           withdraw_amount, Transfer_Amount, deposit_amount,
    output Transfer_Successfully, ATM_Usage_Finished, Balance_Shown,
           Deposited_Successfully, Withdrew_Successfully, Pin_Changed_Successfully,
           Receipt_Printed
  );
endinterface

// File: rtl/atm_account_lookup.sv
// Maps an account number to its table index and reports whether it exists.
// Latency: combinational.
// Backpressure: none.
module atm_account_lookup
  import atm_pkg::*;
(
  input  acct_t account,
  output idx_t  idx,
  output logic  hit
);

  // Compare against every fixed account number; numbers are unique so at most one matches.
  always_comb begin
    idx = '0;
    hit = 1'b0;
    for (int i = 0; i < NUM_ACCTS; i++) begin
      if (account == init_account(idx_t'(i))) begin
        idx = idx_t'(i);
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/atm_banking_system.sv
// ATM session controller: card/PIN authentication, one banking operation per pass, status flags.
// Latency: flags are registered; an operation's flag appears the cycle after its EXEC cycle.
// Backpressure: deposit holds in EXEC until money_counting; Timer or card removal aborts to IDLE.
module atm_banking_system
  import atm_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  atm_banking_system_if.slave   bus
);

  state_t      state_q, state_d;
  logic [1:0]  fail_cnt_q, fail_cnt_d;
  acct_t       acct_q, acct_d;
  logic [2:0]  op_q, op_d;
  logic        ok_q, ok_d;
  flags_t      flags_q, flags_d;
  amount_t     bal_q [NUM_ACCTS];
  amount_t     bal_d [NUM_ACCTS];
  pin_t        pin_q [NUM_ACCTS];
  pin_t        pin_d [NUM_ACCTS];

  idx_t        src_idx, dst_idx;
  logic        src_hit, dst_hit;
  logic        abort;
  logic [15:0] dep_sum, xfer_sum;

  atm_account_lookup u_src_lookup (
    .account (acct_q),
    .idx     (src_idx),
    .hit     (src_hit)
  );

  atm_account_lookup u_dst_lookup (
    .account (bus.Pers_Account_No),
    .idx     (dst_idx),
    .hit     (dst_hit)
  );

  // A 16-bit sum with bit 15 set means the new balance no longer fits in 15 bits.
  assign dep_sum  = {1'b0, bal_q[src_idx]} + {1'b0, bus.deposit_amount};
  assign xfer_sum = {1'b0, bal_q[dst_idx]} + {1'b0, bus.Transfer_Amount};
  assign abort    = (state_q != ST_IDLE) && (bus.Timer || !bus.Card_in);

  // Next-state, table-update and flag decode; abort overrides everything at the end.
  always_comb begin
    state_d    = state_q;
    fail_cnt_d = fail_cnt_q;
    acct_d     = acct_q;
    op_d       = op_q;
    ok_d       = ok_q;
    flags_d    = '0;
    for (int i = 0; i < NUM_ACCTS; i++) begin
      bal_d[i] = bal_q[i];
      pin_d[i] = pin_q[i];
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.Card_in) begin
          acct_d  = bus.ur_account;
          state_d = ST_AUTH;
        end
      end
      ST_AUTH: begin
        if (!src_hit) begin
          state_d    = ST_IDLE;
          fail_cnt_d = '0;
        end else if (bus.password == pin_q[src_idx]) begin
          state_d    = ST_MENU;
          fail_cnt_d = '0;
        end else if (fail_cnt_q == 2'd2) begin
          state_d    = ST_IDLE;
          fail_cnt_d = '0;
        end else begin
          fail_cnt_d = fail_cnt_q + 2'd1;
        end
      end
      ST_MENU: begin
        if (opcode_valid(bus.opcode)) begin
          op_d    = bus.opcode;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        ok_d    = 1'b0;
        state_d = ST_DONE;
        case (op_q)
          OP_BALANCE: begin
            ok_d            = 1'b1;
            flags_d.balance = 1'b1;
          end
          OP_WITHDRAW: begin
            if (bus.withdraw_amount <= bal_q[src_idx]) begin
              bal_d[src_idx]   = bal_q[src_idx] - bus.withdraw_amount;
              ok_d             = 1'b1;
              flags_d.withdraw = 1'b1;
            end
          end
          OP_DEPOSIT: begin
            if (!bus.money_counting) begin
              state_d = ST_EXEC;
              ok_d    = ok_q;
            end else if (!dep_sum[15]) begin
              bal_d[src_idx]  = dep_sum[14:0];
              ok_d            = 1'b1;
              flags_d.deposit = 1'b1;
            end
          end
          OP_TRANSFER: begin
            if (dst_hit && (dst_idx != src_idx) &&
                (bus.Transfer_Amount <= bal_q[src_idx]) && !xfer_sum[15]) begin
              bal_d[src_idx]   = bal_q[src_idx] - bus.Transfer_Amount;
              bal_d[dst_idx]   = xfer_sum[14:0];
              ok_d             = 1'b1;
              flags_d.transfer = 1'b1;
            end
          end
          default: begin
            pin_d[src_idx] = bus.new_pin;
            ok_d           = 1'b1;
            flags_d.pin    = 1'b1;
          end
        endcase
      end
      ST_DONE: begin
        state_d         = ST_ANOTHER;
        flags_d.receipt = bus.take_receipt && ok_q;
      end
      ST_ANOTHER: begin
        if (bus.another_transaction_bit) begin
          state_d = ST_MENU;
        end else begin
          state_d          = ST_IDLE;
          flags_d.finished = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d    = ST_IDLE;
      fail_cnt_d = '0;
      flags_d    = '0;
      for (int i = 0; i < NUM_ACCTS; i++) begin
        bal_d[i] = bal_q[i];
        pin_d[i] = pin_q[i];
      end
    end
  end

  // State, session registers, flags and account table; reset restores the factory table.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      fail_cnt_q <= '0;
      acct_q     <= '0;
      op_q       <= '0;
      ok_q       <= 1'b0;
      flags_q    <= '0;
      for (int i = 0; i < NUM_ACCTS; i++) begin
        bal_q[i] <= init_balance(idx_t'(i));
        pin_q[i] <= init_pin(idx_t'(i));
      end
    end else begin
      state_q    <= state_d;
      fail_cnt_q <= fail_cnt_d;
      acct_q     <= acct_d;
      op_q       <= op_d;
      ok_q       <= ok_d;
      flags_q    <= flags_d;
      for (int i = 0; i < NUM_ACCTS; i++) begin
        bal_q[i] <= bal_d[i];
        pin_q[i] <= pin_d[i];
      end
    end
  end

  assign bus.Transfer_Successfully    = flags_q.transfer;
  assign bus.ATM_Usage_Finished       = flags_q.finished;
  assign bus.Balance_Shown            = flags_q.balance;
  assign bus.Deposited_Successfully   = flags_q.deposit;
  assign bus.Withdrew_Successfully    = flags_q.withdraw;
  assign bus.Pin_Changed_Successfully = flags_q.pin;
  assign bus.Receipt_Printed          = flags_q.receipt;

endmodule

// File: tb/tb_atm_banking_system.sv
// Directed and randomized sessions against a behavioural account model.
// Latency: n/a.
// Backpressure: n/a.
module tb_atm_banking_system;

  localparam logic [6:0] F_TR  = 7'h40;
  localparam logic [6:0] F_FIN = 7'h20;
  localparam logic [6:0] F_BAL = 7'h10;
  localparam logic [6:0] F_DEP = 7'h08;
  localparam logic [6:0] F_WD  = 7'h04;
  localparam logic [6:0] F_PIN = 7'h02;
  localparam logic [6:0] F_RCP = 7'h01;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  atm_banking_system_if bus ();

  atm_banking_system dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fails  = 0;

  logic [16:0] m_acct [4];
  logic [16:0] m_pin  [4];
  int          m_bal  [4];

  logic [6:0] flags;
  assign flags = {bus.Transfer_Successfully, bus.ATM_Usage_Finished, bus.Balance_Shown,
                  bus.Deposited_Successfully, bus.Withdrew_Successfully,
                  bus.Pin_Changed_Successfully, bus.Receipt_Printed};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bals(input string tag);
    check({tag, "_bal0"}, 32'(dut.bal_q[0]), 32'(m_bal[0]));
    check({tag, "_bal1"}, 32'(dut.bal_q[1]), 32'(m_bal[1]));
    check({tag, "_bal2"}, 32'(dut.bal_q[2]), 32'(m_bal[2]));
    check({tag, "_bal3"}, 32'(dut.bal_q[3]), 32'(m_bal[3]));
  endtask

  task automatic model_reset();
    m_acct = '{17'h0C5AA, 17'h0705C, 17'h004D2, 17'h09ABC};
    m_pin  = '{17'h01F5E, 17'h00F0F, 17'h02468, 17'h01357};
    m_bal  = '{32'h0500, 32'h0200, 32'h0100, 32'h7F00};
  endtask

  // Banking rules in plain arithmetic; returns the flag expected in DONE.
  function automatic logic [6:0] model_exec(input int s, input logic [2:0] op, input int amt,
                                            input logic [16:0] dst, input logic [16:0] npin);
    int d;
    d = -1;
    for (int i = 0; i < 4; i++) if (m_acct[i] == dst) d = i;
    case (op)
      3'b001: return F_BAL;
      3'b010: if (amt <= m_bal[s]) begin m_bal[s] -= amt; return F_WD; end
      3'b011: if (m_bal[s] + amt <= 32767) begin m_bal[s] += amt; return F_DEP; end
      3'b100: if (d >= 0 && d != s && amt <= m_bal[s] && m_bal[d] + amt <= 32767) begin
                m_bal[s] -= amt; m_bal[d] += amt; return F_TR;
              end
      3'b101: begin m_pin[s] = npin; return F_PIN; end
      default: return 7'h00;
    endcase
    return 7'h00;
  endfunction

  task automatic idle_inputs();
    bus.Card_in = 0; bus.Timer = 0; bus.money_counting = 0; bus.another_transaction_bit = 0;
    bus.opcode = 0; bus.password = 0; bus.new_pin = 0; bus.take_receipt = 0;
    bus.ur_account = 0; bus.Pers_Account_No = 0; bus.withdraw_amount = 0;
    bus.Transfer_Amount = 0; bus.deposit_amount = 0;
  endtask

  task automatic login(input int s);
    bus.Card_in = 1; bus.ur_account = m_acct[s]; bus.password = m_pin[s];
    tick();
    check("auth_flags", 32'(flags), 32'h0);
    tick();
    check("menu_flags", 32'(flags), 32'h0);
  endtask

  // Starts in MENU; leaves in MENU (another=1) or IDLE with the card removed.
  task automatic run_txn(input string tag, input int s, input logic [2:0] op, input logic [14:0] amt,
                         input logic [16:0] dst, input logic [16:0] npin, input bit rcp,
                         input bit another);
    logic [6:0] exp;
    bus.opcode = op; bus.withdraw_amount = amt; bus.Transfer_Amount = amt;
    bus.deposit_amount = amt; bus.Pers_Account_No = dst; bus.new_pin = npin;
    bus.money_counting = 1;
    tick();
    bus.opcode = 3'b000;
    tick();
    exp = model_exec(s, op, int'(amt), dst, npin);
    check({tag, "_done"}, 32'(flags), 32'(exp));
    bus.take_receipt = rcp;
    tick();
    check({tag, "_rcpt"}, 32'(flags), (rcp && exp != 0) ? 32'(F_RCP) : 32'h0);
    bus.take_receipt = 0; bus.another_transaction_bit = another;
    tick();
    check({tag, "_next"}, 32'(flags), another ? 32'h0 : 32'(F_FIN));
    check_bals(tag);
    bus.another_transaction_bit = 0; bus.money_counting = 0;
    if (!another) begin
      bus.Card_in = 0;
      tick();
      check({tag, "_idle"}, 32'(flags), 32'h0);
    end
  endtask

  initial begin
    int s;
    logic [2:0]  op;
    logic [14:0] amt;
    logic [16:0] dst;
    int c;

    model_reset();
    idle_inputs();
    reset = 0;
    tick(); tick();
    check("reset_flags", 32'(flags), 32'h0);
    check_bals("reset");
    reset = 1;

    // Withdraw, then deposit with receipt, on C5AA.
    login(0);
    run_txn("wd", 0, 3'b010, 15'h0044, 17'h0, 17'h0, 0, 1);
    check("wd_const", 32'(dut.bal_q[0]), 32'h04BC);
    run_txn("dep", 0, 3'b011, 15'h0022, 17'h0, 17'h0, 1, 1);
    check("dep_const", 32'(dut.bal_q[0]), 32'h04DE);
    // Transfers that must fail, then one that succeeds.
    run_txn("xfer_miss", 0, 3'b100, 15'd200, 17'h01111, 17'h0, 1, 1);
    run_txn("xfer_self", 0, 3'b100, 15'd200, 17'h0C5AA, 17'h0, 0, 1);
    run_txn("xfer_ok", 0, 3'b100, 15'd200, 17'h004D2, 17'h0, 0, 0);
    check("xfer_dst_const", 32'(dut.bal_q[2]), 32'h01C8);

    // Three wrong PINs lock out; a fresh login then needs one extra cycle to re-latch.
    bus.Card_in = 1; bus.ur_account = 17'h0705C; bus.password = 17'h01234;
    tick(); tick(); tick(); tick();
    check("lock_flags", 32'(flags), 32'h0);
    bus.password = m_pin[1]; bus.opcode = 3'b001;
    tick(); tick(); tick();
    check("lock_no_early", 32'(flags), 32'h0);
    tick();
    check("lock_relogin_bal", 32'(flags), 32'(F_BAL));
    bus.opcode = 0;
    tick();
    tick();
    check("finish_pulse", 32'(flags), 32'(F_FIN));
    bus.Card_in = 0;
    tick();

    // Deposit waits while money is being counted.
    login(2);
    bus.opcode = 3'b011; bus.deposit_amount = 15'h0010; bus.money_counting = 0;
    tick(); tick(); tick();
    check("dep_wait", 32'(flags), 32'h0);
    check_bals("dep_wait");
    bus.money_counting = 1;
    tick();
    check("dep_wait_done", 32'(flags), 32'(model_exec(2, 3'b011, 16, 17'h0, 17'h0)));
    check_bals("dep_wait_done");
    bus.money_counting = 0; bus.opcode = 0;
    tick();
    tick();
    bus.Card_in = 0;
    tick();

    // Timer during EXEC aborts with no balance change.
    login(0);
    bus.opcode = 3'b010; bus.withdraw_amount = 15'h0010;
    tick();
    bus.Timer = 1;
    tick();
    check("timer_flags", 32'(flags), 32'h0);
    check_bals("timer");
    bus.Timer = 0; bus.Card_in = 0; bus.opcode = 0;
    tick();
    check("timer_idle", 32'(flags), 32'h0);

    // Randomized sessions, with an invalid opcode parked in MENU first.
    for (int k = 0; k < 30; k++) begin
      s = $urandom_range(0, 3);
      login(s);
      bus.opcode = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'b110 + 3'($urandom_range(0, 1));
      tick();
      check("rand_invalid_op", 32'(flags), 32'h0);
      for (int t = 0; t < 2; t++) begin
        op  = 3'($urandom_range(1, 5));
        amt = ($urandom_range(0, 3) == 0) ? 15'($urandom_range(0, 32767))
                                          : 15'($urandom_range(0, 1023));
        c   = $urandom_range(0, 4);
        dst = (c == 4) ? 17'h01111 : m_acct[c];
        run_txn("rand", s, op, amt, dst, 17'($urandom_range(0, 17'h1FFFF)),
                1'($urandom_range(0, 1)), t == 0);
      end
    end

    // Reset mid-operation restores the factory table.
    login(3);
    bus.opcode = 3'b010; bus.withdraw_amount = 15'h0005;
    tick();
    reset = 0;
    tick();
    model_reset();
    check("midreset_flags", 32'(flags), 32'h0);
    check_bals("midreset");
    reset = 1;
    idle_inputs();
    tick();
    login(0);
    run_txn("post_reset_bal", 0, 3'b001, 15'h0, 17'h0, 17'h0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
